cache_ctrl_wb: RTL and testbench

Parametrised write-back, direct-mapped cache controller that owns its tag, valid, dirty and data arrays. It serves processor read, write, flush and indirect (pointer-dereference) requests over a valid/ready request port and a one-cycle response pulse. It talks to backing RAM through an enable/ready handshake that tolerates variable RAM latency. It sits between the processor datapath and main memory, and adds full-cache flush, write-allocate without fetch, reset and hit/miss counters.

---
 rtl/cache_ctrl_wb.sv | 269 ++++++++++++++++++++++++++
 tb/tb_cache_ctrl_wb.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_wb.sv
// cache_ctrl_wb: write-back, direct-mapped cache controller, one word per line.
//   Serves flush/nop/read/write (optionally indirect) requests and talks to RAM
//   through held enables that wait for ram_ready, so any RAM latency works.
// Latency: nop +1, hit or clean write-miss +2, clean read miss 3 + FILL cycles,
//   clean flush LINES+1 (cycles counted from the accept edge).
// Backpressure: req_ready only in IDLE; req_valid while not ready is ignored.
// Ports: clk/rst (sync, active-high); req_* request port; resp_valid/resp_data
//   completion pulse; ram_* backing-memory handshake; hit_count/miss_count
//   saturating lookup counters.
module cache_ctrl_wb #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int INDEX_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic              req_indirect,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              ram_rd_en,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOOKUP     = 3'd1;
  localparam logic [2:0] S_EVICT      = 3'd2;
  localparam logic [2:0] S_FILL       = 3'd3;
  localparam logic [2:0] S_FLUSH_SCAN = 3'd4;
  localparam logic [2:0] S_FLUSH_WB   = 3'd5;
  localparam logic [2:0] S_RESP       = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic              ind_q, ind_d;
  logic [INDEX_W-1:0] scan_q, scan_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [15:0]       hit_q, hit_d;
  logic [15:0]       miss_q, miss_d;

  // Tag and data arrays carry no reset: a line is meaningless until valid.
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  logic              line_we;
  logic [INDEX_W-1:0] line_idx;
  logic [TAG_W-1:0]  line_tag;
  logic [DATA_W-1:0] line_data;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic [ADDR_W-1:0] ptr;

  assign idx = addr_q[INDEX_W-1:0];
  assign tag = addr_q[ADDR_W-1:INDEX_W];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  // Pointer value read from a cached word, fitted to the address width.
  generate
    if (DATA_W >= ADDR_W) begin : g_ptr_trunc
      assign ptr = data_q[idx][ADDR_W-1:0];
    end else begin : g_ptr_zext
      assign ptr = {{(ADDR_W-DATA_W){1'b0}}, data_q[idx]};
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    ind_d       = ind_q;
    scan_d      = scan_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    resp_data_d = resp_data_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    line_we     = 1'b0;
    line_idx    = idx;
    line_tag    = tag;
    line_data   = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          is_wr_d     = req_op[0];
          ind_d       = req_indirect & req_op[1];
          resp_data_d = '0;
          case (req_op)
            2'b00: begin
              scan_d  = '0;
              state_d = S_FLUSH_SCAN;
            end
            2'b01:   state_d = S_RESP;
            default: state_d = S_LOOKUP;
          endcase
        end
      end

      S_LOOKUP: begin
        if (hit) begin
          if (hit_q != 16'hFFFF) hit_d = hit_q + 16'd1;
          if (ind_q) begin
            // Dereference and re-run the lookup on the pointed-to address.
            addr_d = ptr;
            ind_d  = 1'b0;
          end else if (!is_wr_q) begin
            resp_data_d = data_q[idx];
            state_d     = S_RESP;
          end else begin
            line_we       = 1'b1;
            dirty_d[idx]  = 1'b1;
            state_d       = S_RESP;
          end
        end else begin
          if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
          if (valid_q[idx] && dirty_q[idx]) begin
            state_d = S_EVICT;
          end else if (is_wr_q && !ind_q) begin
            // Whole-word write: no need to fetch the old contents.
            line_we      = 1'b1;
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b1;
            state_d      = S_RESP;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      S_EVICT: begin
        if (ram_ready) begin
          dirty_d[idx] = 1'b0;
          state_d      = S_LOOKUP;
        end
      end

      S_FILL: begin
        if (ram_ready) begin
          line_we      = 1'b1;
          line_data    = ram_rdata;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = S_LOOKUP;
        end
      end

      S_FLUSH_SCAN: begin
        if (valid_q[scan_q] && dirty_q[scan_q]) begin
          state_d = S_FLUSH_WB;
        end else begin
          valid_d[scan_q] = 1'b0;
          dirty_d[scan_q] = 1'b0;
          if (&scan_q) begin
            state_d = S_RESP;
          end else begin
            scan_d  = scan_q + 1'b1;
            state_d = S_FLUSH_SCAN;
          end
        end
      end

      S_FLUSH_WB: begin
        if (ram_ready) begin
          valid_d[scan_q] = 1'b0;
          dirty_d[scan_q] = 1'b0;
          if (&scan_q) begin
            state_d = S_RESP;
          end else begin
            scan_d  = scan_q + 1'b1;
            state_d = S_FLUSH_SCAN;
          end
        end
      end

      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      ind_q       <= 1'b0;
      scan_q      <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      resp_data_q <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_wr_q     <= is_wr_d;
      ind_q       <= ind_d;
      scan_q      <= scan_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      resp_data_q <= resp_data_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= line_data;
    end
  end

  // RAM side is decoded from state so enables fall as soon as state leaves
  // EVICT/FILL/FLUSH_WB, including on reset; only one can be high at a time.
  always_comb begin
    ram_rd_en = 1'b0;
    ram_wr_en = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state_q)
      S_FILL: begin
        ram_rd_en = 1'b1;
        ram_addr  = addr_q;
      end
      S_EVICT: begin
        ram_wr_en = 1'b1;
        ram_addr  = {tag_q[idx], idx};
        ram_wdata = data_q[idx];
      end
      S_FLUSH_WB: begin
        ram_wr_en = 1'b1;
        ram_addr  = {tag_q[scan_q], scan_q};
        ram_wdata = data_q[scan_q];
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = resp_data_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// tb_cache_ctrl_wb: randomized and directed bench for cache_ctrl_wb.
//   Reference: a flat logical memory plus a per-index record of which address
//   is resident, from which read data, hit/miss counts and writebacks follow.
module tb_cache_ctrl_wb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'b01;
  logic       req_indirect = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, resp_valid;
  logic [7:0] resp_data;
  logic       ram_rd_en, ram_wr_en;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic       ram_ready = 1'b0;
  logic [15:0] hit_count, miss_count;

  cache_ctrl_wb #(.DATA_W(8), .ADDR_W(8), .INDEX_W(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_indirect(req_indirect), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram_mem [256];
  logic [7:0] mem_ref [256];
  logic [7:0] res_addr [8];
  bit         res_v [8];
  bit         res_d [8];
  int         exp_hits, exp_misses;
  int         fixed_lat = -1;
  bit         ram_stall = 1'b0;
  logic [7:0] rd_log [$];
  logic [7:0] wr_log_a [$];
  logic [7:0] wr_log_d [$];
  int         rd_cyc = 0;
  int         wr_cyc = 0;

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < 256; i++) mem_ref[i] = ram_mem[i];
    for (int i = 0; i < 8; i++) begin res_v[i] = 0; res_d[i] = 0; res_addr[i] = '0; end
    exp_hits = 0;
    exp_misses = 0;
  endfunction

  // One cache access to address a; alloc_wr means a non-indirect write that
  // allocates without fetching. A dirty victim costs a second miss.
  function automatic void m_access(input logic [7:0] a, input bit alloc_wr);
    int i;
    i = int'(a[2:0]);
    if (res_v[i] && res_addr[i] == a) begin exp_hits++; return; end
    exp_misses++;
    if (res_v[i] && res_d[i]) begin exp_misses++; res_d[i] = 0; end
    res_v[i] = 1;
    res_addr[i] = a;
    if (!alloc_wr) exp_hits++;
  endfunction

  function automatic logic [7:0] model_op(input logic [1:0] op, input logic ind,
                                          input logic [7:0] a, input logic [7:0] wd);
    logic [7:0] tgt;
    tgt = a;
    if (op == 2'b00) begin
      for (int i = 0; i < 8; i++) begin res_v[i] = 0; res_d[i] = 0; end
      return 8'h00;
    end
    if (op == 2'b01) return 8'h00;
    if (ind) begin m_access(a, 0); tgt = mem_ref[a]; end
    if (op == 2'b10) begin m_access(tgt, 0); return mem_ref[tgt]; end
    m_access(tgt, 1);
    res_d[tgt[2:0]] = 1;
    mem_ref[tgt] = wd;
    return 8'h00;
  endfunction

  // ---------------- RAM responder and monitors ----------------
  initial begin
    logic [7:0] a0;
    int lat;
    forever begin
      @(negedge clk);
      if ((ram_rd_en || ram_wr_en) && !ram_stall) begin
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        a0 = ram_addr;
        repeat (lat) @(negedge clk);
        if (ram_rd_en || ram_wr_en) begin
          checks++;
          if (ram_addr !== a0) begin
            errors++;
            $display("FAIL ram_addr_stable got %h expected %h", ram_addr, a0);
          end
          if (ram_wr_en) begin
            ram_mem[ram_addr] = ram_wdata;
            wr_log_a.push_back(ram_addr);
            wr_log_d.push_back(ram_wdata);
          end else begin
            ram_rdata = ram_mem[ram_addr];
            rd_log.push_back(ram_addr);
          end
          ram_ready = 1'b1;
          @(negedge clk);
          ram_ready = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ram_rd_en) rd_cyc++;
    if (ram_wr_en) wr_cyc++;
    checks++;
    if (ram_rd_en && ram_wr_en) begin
      errors++;
      $display("FAIL one_enable got rd=%b wr=%b expected at most one", ram_rd_en, ram_wr_en);
    end
  end

  // ---------------- drivers ----------------
  task automatic apply_reset();
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rd_log.delete(); wr_log_a.delete(); wr_log_d.delete();
  endtask

  // Presents one request, waits for acceptance and for the response pulse.
  // lat is the number of cycles from the accept edge to resp_valid.
  task automatic do_req(input logic [1:0] op, input logic ind, input logic [7:0] a,
                        input logic [7:0] wd, output logic [7:0] rdata, output int lat);
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_indirect = ind; req_addr = a; req_wdata = wd;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = 8'($urandom);
    req_wdata = 8'($urandom);
    lat = 0;
    while (lat < 3000) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    rdata = resp_data;
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout got no resp_valid expected one within 3000 cycles");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low got %b expected 0", req_ready); end
    checks++; if ({resp_valid, ram_rd_en, ram_wr_en} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b expected 000", {resp_valid, ram_rd_en, ram_wr_en}); end
    checks++; if ({ram_addr, ram_wdata, resp_data} !== 24'h0) begin errors++; $display("FAIL rst_buses got %h expected 0", {ram_addr, ram_wdata, resp_data}); end
    checks++; if ({hit_count, miss_count} !== 32'h0) begin errors++; $display("FAIL rst_counters got %h expected 0", {hit_count, miss_count}); end
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_high got %b expected 1", req_ready); end
  endtask

  task automatic test_read_miss_hit();
    logic [7:0] d, e;
    int lat, rd0;
    ram_mem[8'h15] = 8'hA5;
    apply_reset();
    fixed_lat = 3;
    e = model_op(2'b10, 0, 8'h15, 8'h00);
    do_req(2'b10, 0, 8'h15, 8'h00, d, lat);
    checks++; if (d !== e || e !== 8'hA5) begin errors++; $display("FAIL miss_data got %h expected %h", d, e); end
    checks++; if (rd_log.size() != 1 || rd_log[0] !== 8'h15) begin errors++; $display("FAIL miss_ram_addr got %0d reads expected one at 15", rd_log.size()); end
    // FILL lasts fixed_lat+1 cycles with this responder.
    checks++; if (lat != 3 + fixed_lat + 1) begin errors++; $display("FAIL miss_latency got %0d expected %0d", lat, 3 + fixed_lat + 1); end
    checks++; if (hit_count !== 16'(exp_hits) || miss_count !== 16'(exp_misses)) begin errors++; $display("FAIL miss_counters got %0d/%0d expected %0d/%0d", hit_count, miss_count, exp_hits, exp_misses); end
    fixed_lat = -1;
    rd0 = rd_cyc + wr_cyc;
    e = model_op(2'b10, 0, 8'h15, 8'h00);
    do_req(2'b10, 0, 8'h15, 8'h00, d, lat);
    checks++; if (d !== e) begin errors++; $display("FAIL hit_data got %h expected %h", d, e); end
    checks++; if (lat != 2) begin errors++; $display("FAIL hit_latency got %0d expected 2", lat); end
    checks++; if (rd_cyc + wr_cyc != rd0) begin errors++; $display("FAIL hit_no_ram got %0d enable cycles expected 0", rd_cyc + wr_cyc - rd0); end
    checks++; if (hit_count !== 16'(exp_hits) || miss_count !== 16'(exp_misses)) begin errors++; $display("FAIL hit_counters got %0d/%0d expected %0d/%0d", hit_count, miss_count, exp_hits, exp_misses); end
  endtask

  task automatic test_evict();
    logic [7:0] d, e;
    int lat;
    e = model_op(2'b11, 0, 8'h15, 8'h3C);
    do_req(2'b11, 0, 8'h15, 8'h3C, d, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL wr_hit_latency got %0d expected 2", lat); end
    rd_log.delete(); wr_log_a.delete(); wr_log_d.delete();
    e = model_op(2'b10, 0, 8'h1D, 8'h00);
    do_req(2'b10, 0, 8'h1D, 8'h00, d, lat);
    checks++; if (wr_log_a.size() != 1 || wr_log_a[0] !== 8'h15 || wr_log_d[0] !== 8'h3C) begin errors++; $display("FAIL evict_write got %0d writes expected one 15<-3C", wr_log_a.size()); end
    checks++; if (rd_log.size() != 1 || rd_log[0] !== 8'h1D) begin errors++; $display("FAIL evict_fill got %0d reads expected one at 1D", rd_log.size()); end
    checks++; if (d !== e) begin errors++; $display("FAIL evict_data got %h expected %h", d, e); end
    checks++; if (miss_count !== 16'(exp_misses)) begin errors++; $display("FAIL evict_misses got %0d expected %0d", miss_count, exp_misses); end
  endtask

  task automatic test_write_alloc();
    logic [7:0] d, e;
    int lat, c0;
    apply_reset();
    c0 = rd_cyc + wr_cyc;
    e = model_op(2'b11, 0, 8'h02, 8'h77);
    do_req(2'b11, 0, 8'h02, 8'h77, d, lat);
    checks++; if (lat != 2 || d !== e) begin errors++; $display("FAIL alloc_resp got lat %0d data %h expected 2 %h", lat, d, e); end
    e = model_op(2'b10, 0, 8'h02, 8'h00);
    do_req(2'b10, 0, 8'h02, 8'h00, d, lat);
    checks++; if (d !== e || e !== 8'h77) begin errors++; $display("FAIL alloc_read got %h expected %h", d, e); end
    checks++; if (rd_cyc + wr_cyc != c0) begin errors++; $display("FAIL alloc_no_ram got %0d enable cycles expected 0", rd_cyc + wr_cyc - c0); end
    e = model_op(2'b01, 0, 8'h02, 8'h00);
    do_req(2'b01, 0, 8'h02, 8'h00, d, lat);
    checks++; if (lat != 1 || d !== e) begin errors++; $display("FAIL nop got lat %0d data %h expected 1 %h", lat, d, e); end
  endtask

  task automatic test_indirect();
    logic [7:0] d, e;
    int lat;
    ram_mem[8'h10] = 8'h40;
    ram_mem[8'h40] = 8'h99;
    apply_reset();
    e = model_op(2'b10, 1, 8'h10, 8'h00);
    do_req(2'b10, 1, 8'h10, 8'h00, d, lat);
    checks++; if (d !== e || e !== 8'h99) begin errors++; $display("FAIL ind_read got %h expected %h", d, e); end
    checks++; if (rd_log.size() != 2 || rd_log[0] !== 8'h10 || rd_log[1] !== 8'h40) begin errors++; $display("FAIL ind_fills got %0d reads expected 10 then 40", rd_log.size()); end
    e = model_op(2'b11, 1, 8'h10, 8'h55);
    do_req(2'b11, 1, 8'h10, 8'h55, d, lat);
    checks++; if (wr_log_a.size() != 0 || d !== e) begin errors++; $display("FAIL ind_write got %0d writes data %h expected 0 %h", wr_log_a.size(), d, e); end
    rd_log.delete();
    e = model_op(2'b10, 0, 8'h40, 8'h00);
    do_req(2'b10, 0, 8'h40, 8'h00, d, lat);
    checks++; if (d !== e || e !== 8'h55 || rd_log.size() != 0) begin errors++; $display("FAIL ind_target got %h expected %h", d, e); end
    e = model_op(2'b10, 0, 8'h10, 8'h00);
    do_req(2'b10, 0, 8'h10, 8'h00, d, lat);
    checks++; if (d !== e || e !== 8'h40) begin errors++; $display("FAIL ind_pointer got %h expected %h", d, e); end
    checks++; if (wr_log_a.size() != 1 || wr_log_a[0] !== 8'h40 || wr_log_d[0] !== 8'h55) begin errors++; $display("FAIL ind_wb got %0d writes expected 40<-55", wr_log_a.size()); end
    checks++; if (hit_count !== 16'(exp_hits) || miss_count !== 16'(exp_misses)) begin errors++; $display("FAIL ind_counters got %0d/%0d expected %0d/%0d", hit_count, miss_count, exp_hits, exp_misses); end
  endtask

  task automatic test_flush();
    logic [7:0] d, e;
    int lat;
    apply_reset();
    e = model_op(2'b11, 0, 8'h05, 8'hA1);
    do_req(2'b11, 0, 8'h05, 8'hA1, d, lat);
    e = model_op(2'b11, 0, 8'h08, 8'hB2);
    do_req(2'b11, 0, 8'h08, 8'hB2, d, lat);
    wr_log_a.delete(); wr_log_d.delete(); rd_log.delete();
    e = model_op(2'b00, 0, 8'h00, 8'h00);
    do_req(2'b00, 0, 8'h00, 8'h00, d, lat);
    checks++; if (wr_log_a.size() != 2) begin errors++; $display("FAIL flush_count got %0d expected 2", wr_log_a.size()); end
    else begin
      checks++; if (wr_log_a[0] !== 8'h08 || wr_log_d[0] !== 8'hB2) begin errors++; $display("FAIL flush_first got %h<-%h expected 08<-b2", wr_log_a[0], wr_log_d[0]); end
      checks++; if (wr_log_a[1] !== 8'h05 || wr_log_d[1] !== 8'hA1) begin errors++; $display("FAIL flush_second got %h<-%h expected 05<-a1", wr_log_a[1], wr_log_d[1]); end
    end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_pulse got %b expected 0", resp_valid); end
    e = model_op(2'b10, 0, 8'h08, 8'h00);
    do_req(2'b10, 0, 8'h08, 8'h00, d, lat);
    checks++; if (d !== e || rd_log.size() != 1 || miss_count !== 16'(exp_misses)) begin errors++; $display("FAIL flush_miss got %h misses %0d expected %h %0d", d, miss_count, e, exp_misses); end
    apply_reset();
    e = model_op(2'b00, 0, 8'h00, 8'h00);
    do_req(2'b00, 0, 8'h00, 8'h00, d, lat);
    checks++; if (lat != 9) begin errors++; $display("FAIL flush_clean_latency got %0d expected 9", lat); end
  endtask

  task automatic test_reset_mid_fill();
    logic [7:0] d, e;
    int lat, t;
    ram_mem[8'h21] = 8'h12;
    apply_reset();
    e = model_op(2'b11, 0, 8'h21, 8'hEE);
    do_req(2'b11, 0, 8'h21, 8'hEE, d, lat);
    ram_stall = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_indirect = 1'b0; req_addr = 8'h33;
    @(posedge clk);
    #1 req_valid = 1'b0;
    t = 0;
    while (!ram_rd_en && t < 20) begin @(negedge clk); t++; end
    checks++; if (ram_rd_en !== 1'b1) begin errors++; $display("FAIL mid_fill_reached got %b expected 1", ram_rd_en); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (ram_rd_en !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_drop got rd %b ready %b expected 0 0", ram_rd_en, req_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || hit_count !== 16'h0 || miss_count !== 16'h0) begin errors++; $display("FAIL mid_rst_state got ready %b cnt %0d/%0d expected 1 0/0", req_ready, hit_count, miss_count); end
    ram_stall = 1'b0;
    model_reset();
    e = model_op(2'b10, 0, 8'h21, 8'h00);
    do_req(2'b10, 0, 8'h21, 8'h00, d, lat);
    checks++; if (d !== e || e !== 8'h12 || miss_count !== 16'(exp_misses)) begin errors++; $display("FAIL mid_rst_discard got %h misses %0d expected %h %0d", d, miss_count, e, exp_misses); end
  endtask

  task automatic test_random();
    logic [7:0] d, e, a, wd;
    logic [1:0] op;
    logic ind;
    int r, lat;
    for (int i = 0; i < 256; i++) ram_mem[i] = 8'($urandom);
    apply_reset();
    for (int n = 0; n < 120; n++) begin
      r = int'($urandom_range(0, 11));
      op = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
      ind = ($urandom_range(0, 3) == 0);
      a = 8'($urandom_range(0, 31));
      wd = 8'($urandom);
      e = model_op(op, ind, a, wd);
      do_req(op, ind, a, wd, d, lat);
      checks++; if (d !== e) begin errors++; $display("FAIL rand_data op %0d ind %0d addr %h got %h expected %h", op, ind, a, d, e); end
    end
    checks++; if (hit_count !== 16'(exp_hits) || miss_count !== 16'(exp_misses)) begin errors++; $display("FAIL rand_counters got %0d/%0d expected %0d/%0d", hit_count, miss_count, exp_hits, exp_misses); end
    e = model_op(2'b00, 0, 8'h00, 8'h00);
    do_req(2'b00, 0, 8'h00, 8'h00, d, lat);
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (ram_mem[i] !== mem_ref[i]) begin errors++; $display("FAIL rand_ram_image addr %h got %h expected %h", i[7:0], ram_mem[i], mem_ref[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = 8'(i * 7 + 3);
    test_reset();
    test_read_miss_hit();
    test_evict();
    test_write_alloc();
    test_indirect();
    test_flush();
    test_reset_mid_fill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
